// File: rtl/mem_wb_stage.sv
// MEM stage of the 16-bit pipelined core plus the MEM/WB pipeline register.
// Data memory accesses take MEM_LAT cycles; upstream is stalled until the final cycle.
module mem_wb_stage #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_m,
    input  logic        mem_write_m,
    input  logic        reg_write_m,
    input  logic [15:0] alu_result_m,
    input  logic [15:0] rdata2_m,
    input  logic [2:0]  rd_m,
    output logic        stall_mem,
    output logic [15:0] fwd_data_m,
    output logic        reg_write_w,
    output logic [2:0]  rd_w,
    output logic [15:0] wb_data_w
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0]  addr_c;
    logic               access_c;
    logic               final_c;
    logic               store_fire_c;
    logic [DATA_W-1:0]  load_data_c;

    // Address decode; upper address bits are dropped so accesses wrap.
    assign addr_c       = alu_result_m[ADDR_W-1:0];
    assign access_c     = mem_to_reg_m | mem_write_m;
    assign load_data_c  = mem_q[addr_c];
    assign store_fire_c = final_c & mem_write_m;
    assign fwd_data_m   = alu_result_m;

    // Stall and final-cycle decode; both forced low while reset is held.
    always_comb begin
        stall_mem = 1'b0;
        final_c   = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (access_c) begin
                        if (MEM_LAT > 1) stall_mem = 1'b1;
                        else             final_c   = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) stall_mem = 1'b1;
                    else             final_c   = 1'b1;
                end
                default: begin
                    stall_mem = 1'b0;
                    final_c   = 1'b0;
                end
            endcase
        end
    end

    // Access sequencer: IDLE launches a multi-cycle access, BUSY counts down to the final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_c && (MEM_LAT > 1)) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) cnt_q   <= cnt_q - CNT_W'(1);
                    else             state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Data memory write port; commits only at the edge that ends the final cycle.
    always_ff @(posedge clk) begin
        if (store_fire_c) mem_q[addr_c] <= rdata2_m;
    end

    // MEM/WB register: bubble while stalled, otherwise capture the write-back result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_w <= 1'b0;
            rd_w        <= '0;
            wb_data_w   <= '0;
        end else if (stall_mem) begin
            reg_write_w <= 1'b0;
        end else begin
            reg_write_w <= reg_write_m & (rd_m != 3'd0);
            rd_w        <= rd_m;
            wb_data_w   <= mem_to_reg_m ? load_data_c : alu_result_m;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a MEM_LAT=2 instance and a MEM_LAT=1 instance.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;

    logic        mem_to_reg, mem_write, reg_write;
    logic [15:0] alu, rdata2;
    logic [2:0]  rd;
    logic        stall;
    logic [15:0] fwd;
    logic        rw_w;
    logic [2:0]  rd_w;
    logic [15:0] wb_w;

    logic        l1_mem_to_reg, l1_mem_write, l1_reg_write;
    logic [15:0] l1_alu, l1_rdata2;
    logic [2:0]  l1_rd;
    logic        l1_stall;
    logic [15:0] l1_fwd;
    logic        l1_rw_w;
    logic [2:0]  l1_rd_w;
    logic [15:0] l1_wb_w;

    int n_pass;
    int n_total;

    mem_wb_stage #(.ADDR_W(8), .MEM_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_to_reg_m (mem_to_reg),
        .mem_write_m  (mem_write),
        .reg_write_m  (reg_write),
        .alu_result_m (alu),
        .rdata2_m     (rdata2),
        .rd_m         (rd),
        .stall_mem    (stall),
        .fwd_data_m   (fwd),
        .reg_write_w  (rw_w),
        .rd_w         (rd_w),
        .wb_data_w    (wb_w)
    );

    mem_wb_stage #(.ADDR_W(8), .MEM_LAT(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .mem_to_reg_m (l1_mem_to_reg),
        .mem_write_m  (l1_mem_write),
        .reg_write_m  (l1_reg_write),
        .alu_result_m (l1_alu),
        .rdata2_m     (l1_rdata2),
        .rd_m         (l1_rd),
        .stall_mem    (l1_stall),
        .fwd_data_m   (l1_fwd),
        .reg_write_w  (l1_rw_w),
        .rd_w         (l1_rd_w),
        .wb_data_w    (l1_wb_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic rw,
                         input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
        mem_to_reg = ld; mem_write = st; reg_write = rw;
        alu = a; rdata2 = d; rd = r;
    endtask

    task automatic drive1(input logic ld, input logic st, input logic rw,
                          input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
        l1_mem_to_reg = ld; l1_mem_write = st; l1_reg_write = rw;
        l1_alu = a; l1_rdata2 = d; l1_rd = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 3'd2);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        tick();
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
        else n_pass++;
        n_total++;
        if (rw_w !== 1'b0 || rd_w !== 3'd0 || wb_w !== 16'h0000)
            $display("FAIL reset_wb: got rw=%b rd=%0d wb=%h want 0/0/0000", rw_w, rd_w, wb_w);
        else n_pass++;
        n_total++;
        if (l1_rw_w !== 1'b0 || l1_rd_w !== 3'd0 || l1_wb_w !== 16'h0000)
            $display("FAIL reset_wb_lat1: got rw=%b rd=%0d wb=%h want 0/0/0000", l1_rw_w, l1_rd_w, l1_wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        rst = 1'b0;
    endtask

    // Store then back-to-back load from the same address.
    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 16'h0012, 16'hBEEF, 3'd0);
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL store_stall_first: got %b want 1", stall);
        else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL store_stall_final: got %b want 0", stall);
        else n_pass++;
        n_total++;
        if (rw_w !== 1'b0) $display("FAIL store_bubble: got %b want 0", rw_w);
        else n_pass++;
        tick();
        n_total++;
        if (rw_w !== 1'b0) $display("FAIL store_no_wb: got %b want 0", rw_w);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000, 3'd3);
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL load_stall_first: got %b want 1", stall);
        else n_pass++;
        tick();
        n_total++;
        if (rw_w !== 1'b0 || stall !== 1'b0)
            $display("FAIL load_bubble: got rw=%b stall=%b want 0/0", rw_w, stall);
        else n_pass++;
        tick();
        n_total++;
        if (rw_w !== 1'b1 || rd_w !== 3'd3 || wb_w !== 16'hBEEF)
            $display("FAIL load_result: got rw=%b rd=%0d wb=%h want 1/3/beef", rw_w, rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 3'd5);
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall);
        else n_pass++;
        n_total++;
        if (fwd !== 16'h1234) $display("FAIL alu_fwd: got %h want 1234", fwd);
        else n_pass++;
        tick();
        n_total++;
        if (rw_w !== 1'b1 || rd_w !== 3'd5 || wb_w !== 16'h1234)
            $display("FAIL alu_result: got rw=%b rd=%0d wb=%h want 1/5/1234", rw_w, rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 3'd0);
        tick();
        n_total++;
        if (rw_w !== 1'b0 || rd_w !== 3'd0 || wb_w !== 16'h5555)
            $display("FAIL r0_write: got rw=%b rd=%0d wb=%h want 0/0/5555", rw_w, rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    endtask

    // Address 0x0312 aliases to word 0x12 with an 8-bit address.
    task automatic test_wrap();
        drive(1'b0, 1'b1, 1'b0, 16'h0312, 16'hCAFE, 3'd0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000, 3'd4);
        tick();
        tick();
        n_total++;
        if (rw_w !== 1'b1 || rd_w !== 3'd4 || wb_w !== 16'hCAFE)
            $display("FAIL wrap_load: got rw=%b rd=%0d wb=%h want 1/4/cafe", rw_w, rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    endtask

    task automatic test_reset_mid_access();
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111, 3'd7);
        tick();
        tick();
        n_total++;
        if (rd_w !== 3'd7 || wb_w !== 16'h0020)
            $display("FAIL pre_reset_wb: got rd=%0d wb=%h want 7/0020", rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h2222, 3'd0);
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL midrst_stall_before: got %b want 1", stall);
        else n_pass++;
        n_total++;
        if (fwd !== 16'h0020) $display("FAIL midrst_fwd_stalled: got %h want 0020", fwd);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL midrst_stall_drop: got %b want 0", stall);
        else n_pass++;
        n_total++;
        if (rw_w !== 1'b0 || rd_w !== 3'd0 || wb_w !== 16'h0000)
            $display("FAIL midrst_wb: got rw=%b rd=%0d wb=%h want 0/0/0000", rw_w, rd_w, wb_w);
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        rst = 1'b0;
        tick();
        drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 3'd6);
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL midrst_idle_relaunch: got %b want 1", stall);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (rw_w !== 1'b1 || rd_w !== 3'd6 || wb_w !== 16'h1111)
            $display("FAIL midrst_mem_kept: got rw=%b rd=%0d wb=%h want 1/6/1111", rw_w, rd_w, wb_w);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    endtask

    // Single-cycle memory: no stall, read-before-write on combined load/store.
    task automatic test_lat1();
        drive1(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0001, 3'd0);
        #1;
        n_total++;
        if (l1_stall !== 1'b0) $display("FAIL lat1_store_stall: got %b want 0", l1_stall);
        else n_pass++;
        tick();
        drive1(1'b1, 1'b1, 1'b1, 16'h0040, 16'h00FF, 3'd2);
        #1;
        n_total++;
        if (l1_stall !== 1'b0) $display("FAIL lat1_ldst_stall: got %b want 0", l1_stall);
        else n_pass++;
        tick();
        n_total++;
        if (l1_rw_w !== 1'b1 || l1_rd_w !== 3'd2 || l1_wb_w !== 16'h0001)
            $display("FAIL lat1_ldst_old: got rw=%b rd=%0d wb=%h want 1/2/0001", l1_rw_w, l1_rd_w, l1_wb_w);
        else n_pass++;
        drive1(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 3'd1);
        tick();
        n_total++;
        if (l1_rw_w !== 1'b1 || l1_rd_w !== 3'd1 || l1_wb_w !== 16'h00FF)
            $display("FAIL lat1_mem_new: got rw=%b rd=%0d wb=%h want 1/1/00ff", l1_rw_w, l1_rd_w, l1_wb_w);
        else n_pass++;
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_back_to_back();
        test_alu();
        test_wrap();
        test_reset_mid_access();
        test_lat1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
